// File: rtl/mpq_cmd_sched_if.sv
// Bundle of requester-side and queue-side signals around the command scheduler.
// The scheduler is the slave; whoever drives requests and models the queue is the master.
interface mpq_cmd_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] req_cmd;
    logic [8*N_REQ-1:0] req_index;
    logic [8*N_REQ-1:0] req_value;
    logic [N_REQ-1:0]   ack;
    logic [1:0]         err_code;
    logic               load_valid;
    logic               mpq_busy;
    logic               mpq_done;
    logic               mpq_cmd_valid;
    logic [2:0]         mpq_cmd;
    logic [7:0]         mpq_index;
    logic [7:0]         mpq_value;
    logic [7:0]         occ;
    logic               fault;

    modport slave (
        input  req, req_cmd, req_index, req_value, load_valid, mpq_busy, mpq_done,
        output ack, err_code, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value, occ, fault
    );

    modport master (
        output req, req_cmd, req_index, req_value, load_valid, mpq_busy, mpq_done,
        input  ack, err_code, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value, occ, fault
    );
endinterface

// File: rtl/mpq_cmd_sched.sv
// Round-robin command scheduler for the max-priority-queue engine: one command
// in flight, occupancy tracking to reject illegal commands, watchdog on the engine.
module mpq_cmd_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    mpq_cmd_sched_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] CMD_EXTRACT   = 3'd1;
    localparam logic [2:0] CMD_INCREASE  = 3'd2;
    localparam logic [2:0] CMD_INSERT    = 3'd3;
    localparam logic [2:0] CMD_INC_CONST = 3'd5;

    typedef enum logic [2:0] {
        S_LOAD, S_ARB, S_ISSUE, S_WAIT_ACC, S_WAIT_CMP, S_RESP, S_FAULT
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   r_gid;
    logic [2:0]      r_cmd;
    logic [7:0]      r_index;
    logic [7:0]      r_value;
    logic [7:0]      r_occ;
    logic [9:0]      r_timer;
    logic            r_to_load;
    logic [N_REQ-1:0] r_ack;
    logic [1:0]      r_err;
    logic            r_cmd_valid;
    logic [2:0]      r_mpq_cmd;
    logic [7:0]      r_mpq_index;
    logic [7:0]      r_mpq_value;
    logic            r_fault;

    logic [2:0]      w_cmd [N_REQ];
    logic [7:0]      w_idx [N_REQ];
    logic [7:0]      w_val [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_cmd[gi] = bus.req_cmd[3*gi +: 3];
            assign w_idx[gi] = bus.req_index[8*gi +: 8];
            assign w_val[gi] = bus.req_value[8*gi +: 8];
        end
    endgenerate

    // Scan downward so the requester closest after last_grant is written last and wins.
    logic            w_found;
    logic [GW-1:0]   w_gid;
    logic [GW-1:0]   w_j;
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_j     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_j = GW'((int'(r_last_grant) + k) % N_REQ);
            if (bus.req[w_j]) begin
                w_found = 1'b1;
                w_gid   = w_j;
            end
        end
    end

    logic [2:0] w_scmd;
    logic [7:0] w_sidx;
    logic [7:0] w_sval;
    logic       w_illegal;
    logic       w_wr_latched;
    assign w_scmd = w_cmd[w_gid];
    assign w_sidx = w_idx[w_gid];
    assign w_sval = w_val[w_gid];
    assign w_wr_latched = (r_cmd == 3'd4) || (r_cmd[2:1] == 2'b11);

    always_comb begin
        case (w_scmd)
            CMD_EXTRACT:                 w_illegal = (r_occ == 8'd0);
            CMD_INSERT:                  w_illegal = (r_occ == 8'd255);
            CMD_INCREASE, CMD_INC_CONST: w_illegal = (w_sidx == 8'd0) || (w_sidx > r_occ);
            default:                     w_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_last_grant <= GW'(N_REQ - 1);
            r_gid        <= '0;
            r_cmd        <= '0;
            r_index      <= '0;
            r_value      <= '0;
            r_occ        <= '0;
            r_timer      <= '0;
            r_to_load    <= 1'b0;
            r_ack        <= '0;
            r_err        <= '0;
            r_cmd_valid  <= 1'b0;
            r_mpq_cmd    <= '0;
            r_mpq_index  <= '0;
            r_mpq_value  <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_cmd_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (bus.load_valid && r_occ != 8'd255) r_occ <= r_occ + 8'd1;
                    if (r_occ != 8'd0 && !bus.mpq_busy) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_gid   <= w_gid;
                        r_cmd   <= w_scmd;
                        r_index <= w_sidx;
                        r_value <= w_sval;
                        if (w_illegal) begin
                            r_ack[w_gid] <= 1'b1;
                            r_err        <= 2'd1;
                            r_last_grant <= w_gid;
                            r_to_load    <= 1'b0;
                            r_state      <= S_RESP;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_mpq_cmd   <= w_scmd;
                            r_mpq_index <= w_sidx;
                            r_mpq_value <= w_sval;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_ACC;
                end
                S_WAIT_ACC, S_WAIT_CMP: begin
                    if (r_timer == 10'(TIMEOUT)) begin
                        r_ack[r_gid] <= 1'b1;
                        r_err        <= 2'd2;
                        r_fault      <= 1'b1;
                        r_state      <= S_FAULT;
                    end else if (r_state == S_WAIT_ACC) begin
                        if (bus.mpq_busy) begin
                            r_timer <= '0;
                            r_state <= S_WAIT_CMP;
                        end else begin
                            r_timer <= r_timer + 10'd1;
                        end
                    end else if (w_wr_latched ? bus.mpq_done : !bus.mpq_busy) begin
                        // Completion: acknowledge and account for the element count change.
                        r_ack[r_gid] <= 1'b1;
                        r_err        <= 2'd0;
                        r_last_grant <= r_gid;
                        r_to_load    <= w_wr_latched;
                        if (w_wr_latched)             r_occ <= 8'd0;
                        else if (r_cmd == CMD_EXTRACT) r_occ <= r_occ - 8'd1;
                        else if (r_cmd == CMD_INSERT)  r_occ <= r_occ + 8'd1;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 10'd1;
                    end
                end
                S_RESP:  r_state <= r_to_load ? S_LOAD : S_ARB;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.ack           = r_ack;
    assign bus.err_code      = r_err;
    assign bus.mpq_cmd_valid = r_cmd_valid;
    assign bus.mpq_cmd       = r_mpq_cmd;
    assign bus.mpq_index     = r_mpq_index;
    assign bus.mpq_value     = r_mpq_value;
    assign bus.occ           = r_occ;
    assign bus.fault         = r_fault;
endmodule

// File: tb/tb_mpq_cmd_sched.sv
// Scoreboard bench for mpq_cmd_sched: directed requests push expected acks/issues,
// a negedge monitor pops and compares whatever the scheduler presents.
module tb_mpq_cmd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpq_cmd_sched_if #(.N_REQ(4)) bus ();

    mpq_cmd_sched #(.N_REQ(4), .TIMEOUT(1023)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int gid; int err; int occ; } ack_exp_t;
    typedef struct { int cmd; int idx; int val; } iss_exp_t;
    ack_exp_t ack_q[$];
    iss_exp_t iss_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_acks = 0;

    // Queue engine model controls
    int busy_len  = 5;
    int done_len  = 8;
    int busy_cnt  = 0;
    int done_cnt  = 0;
    bit mute      = 1'b0;
    bit hold_busy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Engine: busy for busy_len cycles after each strobe, done pulse after done_len for write-outs.
    initial begin
        bus.mpq_busy = 1'b1;
        bus.mpq_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.mpq_done = 1'b0;
            if (bus.mpq_cmd_valid && !mute) begin
                busy_cnt = busy_len;
                if (bus.mpq_cmd == 3'd4 || bus.mpq_cmd >= 3'd6) done_cnt = done_len;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) bus.mpq_done = 1'b1;
                end
            end
            bus.mpq_busy = hold_busy || (busy_cnt > 0);
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.ack != 4'b0) begin
                ack_exp_t e;
                n_acks++;
                chk("ack_onehot", {31'b0, $onehot(bus.ack)}, 32'd1);
                if (ack_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_ack: got ack=%b expected none", bus.ack);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_gid", {28'b0, bus.ack}, 32'd1 << e.gid);
                    chk("err_code", {30'b0, bus.err_code}, e.err);
                    chk("occ_at_ack", {24'b0, bus.occ}, e.occ);
                end
            end
            if (!rst && bus.mpq_cmd_valid) begin
                iss_exp_t s;
                if (iss_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_issue: got cmd=%0d expected no issue", bus.mpq_cmd);
                end else begin
                    s = iss_q.pop_front();
                    chk("mpq_cmd", {29'b0, bus.mpq_cmd}, s.cmd);
                    chk("mpq_index", {24'b0, bus.mpq_index}, s.idx);
                    chk("mpq_value", {24'b0, bus.mpq_value}, s.val);
                end
            end
        end
    end

    task automatic set_req(input logic [1:0] id, input int cmd, input int idx, input int val);
        bus.req_cmd[3*id +: 3]   = 3'(cmd);
        bus.req_index[8*id +: 8] = 8'(idx);
        bus.req_value[8*id +: 8] = 8'(val);
        bus.req[id]              = 1'b1;
    endtask

    // One request; optional check of ack latency counted from the cycle req is first sampled.
    task automatic issue_one(input logic [1:0] id, input int cmd, input int idx, input int val,
                             input int exp_err, input int exp_occ, input bit issues,
                             input int exp_lat, input int budget);
        ack_exp_t a;
        iss_exp_t s;
        int cyc;
        a.gid = int'(id); a.err = exp_err; a.occ = exp_occ;
        ack_q.push_back(a);
        if (issues) begin
            s.cmd = cmd; s.idx = idx; s.val = val;
            iss_q.push_back(s);
        end
        @(negedge clk);
        set_req(id, cmd, idx, val);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (bus.ack[id]) break;
            if (cyc > budget) begin
                n_chk++;
                $display("FAIL ack_timeout: got no ack after %0d cycles expected ack[%0d]", cyc, id);
                break;
            end
        end
        bus.req[id] = 1'b0;
        if (exp_lat > 0) chk("ack_latency", cyc, exp_lat);
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    initial begin
        int pending;
        int cyc;
        int acks_before;
        ack_exp_t a;
        iss_exp_t s;
        bus.req        = '0;
        bus.req_cmd    = '0;
        bus.req_index  = '0;
        bus.req_value  = '0;
        bus.load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_occ", {24'b0, bus.occ}, 0);
        chk("rst_fault", {31'b0, bus.fault}, 0);
        chk("rst_ack", {28'b0, bus.ack}, 0);
        chk("rst_cmd_valid", {31'b0, bus.mpq_cmd_valid}, 0);
        rst = 1'b0;

        // Load 6 values while the engine is busy building, then extract on req0.
        load_n(6);
        chk("occ_after_load6", {24'b0, bus.occ}, 6);
        hold_busy = 1'b0;
        busy_len  = 5;
        issue_one(2'd0, 1, 0, 0, 0, 5, 1'b1, -1, 200);

        // All four insert 0x40 at once; last grant was 0, so order is 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            a.gid = (i + 1) % 4; a.err = 0; a.occ = 6 + i;
            ack_q.push_back(a);
            s.cmd = 3; s.idx = 0; s.val = 8'h40;
            iss_q.push_back(s);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(2'(i), 3, 0, 8'h40);
        pending = 4'hF;
        cyc = 0;
        while (pending != 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            pending = pending & ~int'(bus.ack);
            bus.req = bus.req & ~bus.ack;
        end
        chk("all_insert_done", pending, 0);
        bus.req = '0;

        // Bring occ to 6, then increase boundary tests.
        for (int i = 0; i < 3; i++) issue_one(2'd1, 1, 0, 0, 0, 8 - i, 1'b1, -1, 200);
        issue_one(2'd3, 2, 9, 8'h11, 1, 6, 1'b0, 1, 50);
        issue_one(2'd3, 5, 0, 8'h11, 1, 6, 1'b0, 1, 50);
        issue_one(2'd3, 2, 3, 8'hF0, 0, 6, 1'b1, -1, 200);

        // Drain to empty, then extract on empty is rejected without touching the engine.
        for (int i = 0; i < 6; i++) issue_one(2'd0, 1, 0, 0, 0, 5 - i, 1'b1, -1, 200);
        issue_one(2'd2, 1, 0, 0, 1, 0, 1'b0, 1, 50);
        load_n(2);
        chk("load_ignored_in_arb", {24'b0, bus.occ}, 0);

        // Write-out completes on mpq_done, clears occ and returns to loading.
        busy_len = 3;
        done_len = 8;
        issue_one(2'd1, 4, 0, 0, 0, 0, 1'b1, -1, 200);
        hold_busy = 1'b1;
        load_n(3);
        chk("occ_reload", {24'b0, bus.occ}, 3);
        hold_busy = 1'b0;

        // Engine never goes busy: watchdog fires.
        mute = 1'b1;
        issue_one(2'd0, 1, 0, 0, 2, 3, 1'b1, -1, 1500);
        chk("fault_set", {31'b0, bus.fault}, 1);
        acks_before = n_acks;
        set_req(2'd1, 3, 0, 8'h22);
        repeat (30) @(negedge clk);
        chk("fault_ignores_req", n_acks, acks_before);
        chk("fault_sticky", {31'b0, bus.fault}, 1);
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_clears_fault", {31'b0, bus.fault}, 0);
        chk("rst_clears_occ", {24'b0, bus.occ}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("ack_q_empty", ack_q.size(), 0);
        chk("iss_q_empty", iss_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
